// File: rtl/seq_det_pkg.sv
// Purpose : shared types and helpers for the serial pattern detector.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, MAX_LEN default, LEN_W, len_mask().
package seq_det_pkg;

   localparam int MAX_LEN  = 8;
   localparam int LEN_W    = $clog2(MAX_LEN + 1);
   // Width of the mask returned by len_mask; callers keep the low bits they need,
   // so one helper serves any pattern width up to this limit.
   localparam int MASK_MAX = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Low-ones mask: bit i is set when i < len.
   function automatic logic [MASK_MAX-1:0] len_mask(input int len);
      logic [MASK_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_MAX; i++) begin
         m[i] = (i < len);
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_match_shift.sv
// Purpose : serial history shifter, fill counter and masked pattern compare.
// Latency : hit_next is combinational on the cycle the completing bit is shifted in.
// Backpressure: none; a bit is consumed only when shift_en is high.
// Ports   : clk, rst (sync, active high), clr (clears history/fill), shift_en, d,
//           pattern/len (pattern bit len-1 is the oldest bit), hit_next (combinational).
module seq_match_shift #(
   parameter int MAX_LEN = seq_det_pkg::MAX_LEN
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr,
   input  logic                           shift_en,
   input  logic                           d,
   input  logic [MAX_LEN-1:0]             pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   len,
   output logic                           hit_next
);
   import seq_det_pkg::*;

   localparam int              LW   = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0]   FULL = LW'(MAX_LEN);

   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] hist_next;
   logic [MAX_LEN-1:0] mask;
   logic [LW-1:0]      fill;
   logic [LW-1:0]      fill_next;

   always_comb begin
      hist_next = hist;
      fill_next = fill;
      if (shift_en) begin
         hist_next = {hist[MAX_LEN-2:0], d};
         if (fill != FULL) begin
            fill_next = fill + LW'(1);
         end
      end
   end

   assign mask = MAX_LEN'(len_mask(int'(len)));

   // Compare against the post-shift history so the hit lines up with the bit
   // that completes the pattern; fill guards against stale zeros after a clear.
   assign hit_next = shift_en && (fill_next >= len) &&
                     (((hist_next ^ pattern) & mask) == '0);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hist <= '0;
         fill <= '0;
      end else begin
         hist <= hist_next;
         fill <= fill_next;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Purpose : run controller for a programmable serial bit-pattern detector.
// Latency : match/match_cnt/done update on the edge after the completing bit is sampled.
// Backpressure: none; d is sampled only when d_valid is high in RUN, otherwise ignored.
// Ports   : clk, rst (sync, active high); cfg_we + cfg_* config load (IDLE/DONE only);
//           start/abort pulses; d/d_valid serial input; busy, match, match_cnt, done,
//           timed_out, cfg_err status outputs (all registered).
module seq_detect_ctrl #(
   parameter int MAX_LEN = seq_det_pkg::MAX_LEN,
   parameter int CNT_W   = 8,
   parameter int TO_W    = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_we,
   input  logic [MAX_LEN-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
   input  logic [CNT_W-1:0]               cfg_target,
   input  logic [TO_W-1:0]                cfg_timeout,
   input  logic                           start,
   input  logic                           abort,
   input  logic                           d,
   input  logic                           d_valid,
   output logic                           busy,
   output logic                           match,
   output logic [CNT_W-1:0]               match_cnt,
   output logic                           done,
   output logic                           timed_out,
   output logic                           cfg_err
);
   import seq_det_pkg::*;

   localparam int LW = $clog2(MAX_LEN + 1);

   state_t             state;
   logic [MAX_LEN-1:0] pat_q;
   logic [LW-1:0]      len_q;
   logic [CNT_W-1:0]   target_q;
   logic [TO_W-1:0]    timeout_q;
   logic [TO_W-1:0]    to_cnt;

   logic               new_err;
   logic               err_eff;
   logic               run_entry;
   logic               shift_en;
   logic               hit;
   logic [CNT_W-1:0]   cnt_next;

   assign new_err   = (cfg_len == '0) || (cfg_len > LW'(MAX_LEN));
   // A config written alongside start decides whether that start is accepted.
   assign err_eff   = cfg_we ? new_err : cfg_err;
   assign run_entry = (state != RUN) && start && !abort && !err_eff;
   // Abort suppresses the shift so no hit (and no match pulse) can form.
   assign shift_en  = (state == RUN) && d_valid && !abort;
   assign cnt_next  = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);

   seq_match_shift #(
      .MAX_LEN (MAX_LEN)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .clr      (run_entry),
      .shift_en (shift_en),
      .d        (d),
      .pattern  (pat_q),
      .len      (len_q),
      .hit_next (hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         match     <= 1'b0;
         match_cnt <= '0;
         done      <= 1'b0;
         timed_out <= 1'b0;
         cfg_err   <= 1'b0;
         pat_q     <= '0;
         len_q     <= '0;
         target_q  <= '0;
         timeout_q <= '0;
         to_cnt    <= '0;
      end else begin
         match <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (cfg_we) begin
                  pat_q     <= cfg_pattern;
                  len_q     <= cfg_len;
                  target_q  <= cfg_target;
                  timeout_q <= cfg_timeout;
                  cfg_err   <= new_err;
               end
               if (abort) begin
                  state     <= IDLE;
                  done      <= 1'b0;
                  timed_out <= 1'b0;
               end else if (run_entry) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  timed_out <= 1'b0;
                  match_cnt <= '0;
                  to_cnt    <= '0;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (hit) begin
                  // A match restarts the no-match window, so it wins over timeout.
                  match     <= 1'b1;
                  match_cnt <= cnt_next;
                  to_cnt    <= '0;
                  if ((target_q != '0) && (cnt_next == target_q)) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
                  if ((timeout_q != '0) && (to_cnt == timeout_q - TO_W'(1))) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     timed_out <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Purpose : self-checking bench for seq_detect_ctrl with an event scoreboard.
// Latency : expected match/done events carry the clock edge they must appear on.
// Backpressure: n/a.
module tb_seq_detect_ctrl;
   localparam int MAX_LEN = 8;
   localparam int CNT_W   = 8;
   localparam int TO_W    = 16;
   localparam int LW      = 4;

   localparam int EV_MATCH = 0;
   localparam int EV_DONE  = 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LW-1:0]     cfg_len;
   logic [CNT_W-1:0]  cfg_target;
   logic [TO_W-1:0]   cfg_timeout;
   logic              start;
   logic              abort;
   logic              d;
   logic              d_valid;
   logic              busy;
   logic              match;
   logic [CNT_W-1:0]  match_cnt;
   logic              done;
   logic              timed_out;
   logic              cfg_err;

   typedef struct {
      int kind;
      int at;
      int cnt;
      bit to;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic done_q = 1'b0;

   seq_detect_ctrl #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W),
      .TO_W    (TO_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_target  (cfg_target),
      .cfg_timeout (cfg_timeout),
      .start       (start),
      .abort       (abort),
      .d           (d),
      .d_valid     (d_valid),
      .busy        (busy),
      .match       (match),
      .match_cnt   (match_cnt),
      .done        (done),
      .timed_out   (timed_out),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic observe(input int kind);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_%s at edge %0d: got event, expected none",
                  (kind == EV_MATCH) ? "match" : "done", cyc);
         return;
      end
      e = sb.pop_front();
      if (e.kind != kind || e.at != cyc || e.cnt != int'(match_cnt) ||
          (kind == EV_DONE && e.to !== timed_out)) begin
         n_bad++;
         $display("FAIL event: got kind %0d edge %0d cnt %0d to %0b, expected kind %0d edge %0d cnt %0d to %0b",
                  kind, cyc, match_cnt, timed_out, e.kind, e.at, e.cnt, e.to);
      end
   endtask

   // Monitor: every match pulse and every rising edge of done must be expected.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (match === 1'b1) observe(EV_MATCH);
         if (done === 1'b1 && done_q !== 1'b1) observe(EV_DONE);
      end
      done_q = done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int kind, input int at, input int cnt, input bit to);
      exp_t e;
      e.kind = kind;
      e.at   = at;
      e.cnt  = cnt;
      e.to   = to;
      sb.push_back(e);
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l,
                       input logic [7:0] t, input logic [15:0] tv);
      cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_timeout = tv;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // mcnt > 0: a match with that count is due on this edge; fin: done rises too.
   task automatic send(input logic b, input int mcnt, input bit fin);
      d = b;
      d_valid = 1'b1;
      if (mcnt > 0) push(EV_MATCH, cyc + 1, mcnt, 1'b0);
      if (fin)      push(EV_DONE,  cyc + 1, mcnt, 1'b0);
      tick();
      d_valid = 1'b0;
   endtask

   task automatic gap(input logic b);
      d = b;
      d_valid = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
      cfg_timeout = '0; start = 1'b0; abort = 1'b0; d = 1'b0; d_valid = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_match", match, 0);
      check("rst_match_cnt", match_cnt, 0);
      check("rst_done", done, 0);
      check("rst_timed_out", timed_out, 0);
      check("rst_cfg_err", cfg_err, 0);
      rst = 1'b0;
      tick();

      // Overlapping 101 matches, no target.
      load(8'b101, 4'd3, 8'd0, 16'd0);
      go();
      check("t1_busy_start", busy, 1);
      send(1, 0, 0); send(0, 0, 0); send(1, 1, 0); send(0, 0, 0); send(1, 2, 0);
      check("t1_match_cnt", match_cnt, 2);
      check("t1_busy", busy, 1);
      go();
      check("t1_start_in_run_cnt", match_cnt, 2);
      do_abort();
      check("t1_busy_after_abort", busy, 0);

      // Target of 2 ends the run.
      load(8'b101, 4'd3, 8'd2, 16'd0);
      go();
      send(1, 0, 0); send(0, 0, 0); send(1, 1, 0); send(0, 0, 0); send(1, 2, 1);
      check("t2_done", done, 1);
      check("t2_timed_out", timed_out, 0);
      check("t2_busy", busy, 0);
      send(1, 0, 0);
      check("t2_cnt_after_done", match_cnt, 2);

      // Timeout of 5 with only zeros.
      load(8'b1011, 4'd4, 8'd0, 16'd5);
      go();
      push(EV_DONE, cyc + 5, 0, 1'b1);
      repeat (6) send(0, 0, 0);
      check("t3_done", done, 1);
      check("t3_timed_out", timed_out, 1);
      check("t3_match_cnt", match_cnt, 0);

      // Illegal lengths block start.
      do_abort();
      check("t4_done_cleared", done, 0);
      check("t4_timed_out_cleared", timed_out, 0);
      load(8'h00, 4'd0, 8'd0, 16'd0);
      check("t4_err_len0", cfg_err, 1);
      go();
      check("t4_busy_blocked", busy, 0);
      load(8'h00, 4'd9, 8'd0, 16'd0);
      check("t4_err_len9", cfg_err, 1);
      load(8'b11, 4'd2, 8'd0, 16'd0);
      check("t4_err_cleared", cfg_err, 0);
      go();
      check("t4_busy_run", busy, 1);
      do_abort();

      // Abort on the completing bit.
      load(8'b101, 4'd3, 8'd0, 16'd0);
      go();
      send(1, 0, 0); send(0, 0, 0); send(1, 1, 0); send(0, 0, 0);
      d = 1'b1; d_valid = 1'b1; abort = 1'b1;
      tick();
      d_valid = 1'b0; abort = 1'b0;
      check("t5_match", match, 0);
      check("t5_busy", busy, 0);
      check("t5_cnt_held", match_cnt, 1);

      // Reset on the completing bit, with start also high.
      go();
      send(1, 0, 0); send(0, 0, 0); send(1, 1, 0); send(0, 0, 0);
      d = 1'b1; d_valid = 1'b1; rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; d_valid = 1'b0;
      check("t6_busy", busy, 0);
      check("t6_match", match, 0);
      check("t6_match_cnt", match_cnt, 0);
      check("t6_done", done, 0);
      check("t6_timed_out", timed_out, 0);
      check("t6_cfg_err", cfg_err, 0);

      // Gapped input, then a config write in RUN that must be ignored.
      load(8'b101, 4'd3, 8'd2, 16'd0);
      go();
      send(1, 0, 0); gap(1); send(0, 0, 0); gap(1); gap(1); send(1, 1, 0);
      cfg_we = 1'b1; cfg_pattern = 8'b111; cfg_len = 4'd3; cfg_target = 8'd0;
      tick();
      cfg_we = 1'b0;
      send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 2, 1);
      check("t7_done", done, 1);
      check("t7_match_cnt", match_cnt, 2);

      // Config written with start; a match on the timeout cycle wins.
      do_abort();
      cfg_we = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_target = 8'd0;
      cfg_timeout = 16'd3; start = 1'b1;
      tick();
      cfg_we = 1'b0; start = 1'b0;
      check("t8_busy", busy, 1);
      send(0, 0, 0); send(0, 0, 0); send(1, 1, 0);
      check("t8_no_timeout", done, 0);
      check("t8_busy_after", busy, 1);
      do_abort();
      repeat (2) tick();

      check("scoreboard_left", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
